// File: rtl/pc_stack_unit_if.sv
// Control-unit <-> PC/return-stack signal bundle for pc_stack_unit.
interface pc_stack_unit_if #(
  parameter int PC_WIDTH    = 8,
  parameter int STACK_DEPTH = 8
);
  logic                               pc_en;
  logic                               mux_pc_branch;
  logic                               call;
  logic                               ret;
  logic [PC_WIDTH-1:0]                branch_addr;
  logic [PC_WIDTH-1:0]                pc;
  logic [$clog2(STACK_DEPTH+1)-1:0]   sp_count;
  logic                               stack_full;
  logic                               stack_empty;
  logic                               halted;

  modport master (
    output pc_en, mux_pc_branch, call, ret, branch_addr,
    input  pc, sp_count, stack_full, stack_empty, halted
  );

  modport slave (
    input  pc_en, mux_pc_branch, call, ret, branch_addr,
    output pc, sp_count, stack_full, stack_empty, halted
  );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with a circular return-address stack (call/ret/branch/increment).
// STACK_FAULT_TRAP_EN: overflow/underflow halts the unit instead of wrapping/incrementing.
module pc_stack_unit #(
  parameter int PC_WIDTH    = 8,
  parameter int STACK_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  pc_stack_unit_if.slave bus
);
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int PW  = $clog2(STACK_DEPTH);
  localparam logic [PC_WIDTH-1:0] PC_ONE  = 1;
  localparam logic [SPW-1:0]      SP_ONE  = 1;
  localparam logic [SPW-1:0]      SP_FULL = SPW'(STACK_DEPTH);
  localparam logic [PW-1:0]       WP_ONE  = 1;
  localparam logic [PW-1:0]       WP_LAST = PW'(STACK_DEPTH - 1);

  logic [PC_WIDTH-1:0] r_pc, w_pc_nxt, w_pc_inc;
  logic [SPW-1:0]      r_sp, w_sp_nxt;
  logic [PW-1:0]       r_wp, w_wp_nxt, w_wp_inc, w_wp_dec;
  logic [PC_WIDTH-1:0] r_stack [STACK_DEPTH];
  logic                w_push, w_full, w_empty, w_run;

  // r_wp is the next write slot; overwriting it when full drops the oldest entry
  assign w_pc_inc = r_pc + PC_ONE;
  assign w_wp_inc = (r_wp == WP_LAST) ? '0 : r_wp + WP_ONE;
  assign w_wp_dec = (r_wp == '0) ? WP_LAST : r_wp - WP_ONE;
  assign w_full   = (r_sp == SP_FULL);
  assign w_empty  = (r_sp == '0);

`ifdef STACK_FAULT_TRAP_EN
  typedef enum logic {ST_RUN, ST_HALT} state_t;
  state_t r_state, w_state_nxt;
  logic   w_fault;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_fault) w_state_nxt = ST_HALT;
  end

  assign w_run      = (r_state == ST_RUN);
  assign bus.halted = (r_state == ST_HALT);
`else
  assign w_run      = 1'b1;
  assign bus.halted = 1'b0;
`endif

  always_comb begin
    w_pc_nxt = r_pc;
    w_sp_nxt = r_sp;
    w_wp_nxt = r_wp;
    w_push   = 1'b0;
`ifdef STACK_FAULT_TRAP_EN
    w_fault  = 1'b0;
`endif
    if (bus.pc_en && w_run) begin
      if (bus.ret) begin
        if (!w_empty) begin
          w_pc_nxt = r_stack[w_wp_dec];
          w_sp_nxt = r_sp - SP_ONE;
          w_wp_nxt = w_wp_dec;
        end else begin
`ifdef STACK_FAULT_TRAP_EN
          w_fault  = 1'b1;
`else
          w_pc_nxt = w_pc_inc;
`endif
        end
      end else if (bus.call) begin
        if (!w_full) begin
          w_push   = 1'b1;
          w_pc_nxt = bus.branch_addr;
          w_sp_nxt = r_sp + SP_ONE;
          w_wp_nxt = w_wp_inc;
        end else begin
`ifdef STACK_FAULT_TRAP_EN
          w_fault  = 1'b1;
`else
          w_push   = 1'b1;
          w_pc_nxt = bus.branch_addr;
          w_wp_nxt = w_wp_inc;
`endif
        end
      end else if (bus.mux_pc_branch) begin
        w_pc_nxt = bus.branch_addr;
      end else begin
        w_pc_nxt = w_pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= '0;
      r_sp <= '0;
      r_wp <= '0;
    end else begin
      r_pc <= w_pc_nxt;
      r_sp <= w_sp_nxt;
      r_wp <= w_wp_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst) r_stack[r_wp] <= w_pc_inc;
  end

  assign bus.pc          = r_pc;
  assign bus.sp_count    = r_sp;
  assign bus.stack_full  = w_full;
  assign bus.stack_empty = w_empty;
endmodule
